// File: rtl/eth_phy_reset_seq.sv
// rtl/eth_phy_reset_seq.sv - Ethernet PHY reset sequencer, speed debounce and EMIF status sync
module eth_phy_reset_seq #(
  parameter int RST_CYCLES    = 500000,
  parameter int WAIT_CYCLES   = 250000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nenet_reg_reset,
  input  logic       pll_locked,
  input  logic       phy_speed100,
  input  logic       emif_init_done,
  input  logic       emif_cal_success,
  input  logic       emif_cal_fail,
  output logic       phy_resetn,
  output logic       mac_set_10,
  output logic       mac_set_1000,
  output logic       eth_ready,
  output logic [2:0] ddr3_status,
  output logic [7:0] reset_count
);

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stable_cnt;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic             pll_locked_s;
  logic             phy_speed100_s;
  logic             hold;

  // Bit order: {cal_fail, cal_success, init_done, speed100, pll_locked}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {emif_cal_fail, emif_cal_success, emif_init_done, phy_speed100, pll_locked};
      sync2 <= sync1;
    end
  end

  assign pll_locked_s   = sync2[0];
  assign phy_speed100_s = sync2[1];
  assign ddr3_status    = sync2[4:2];
  assign mac_set_1000   = 1'b0;
  assign hold           = nenet_reg_reset | ~pll_locked_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      phy_resetn  <= 1'b0;
      eth_ready   <= 1'b0;
      reset_count <= '0;
    end else if (hold) begin
      // Only a restart out of RELEASE/RUN is counted; a persisting hold is not.
      if (state != ST_ASSERT && reset_count != 8'hff)
        reset_count <= reset_count + 8'd1;
      state      <= ST_ASSERT;
      cnt        <= '0;
      phy_resetn <= 1'b0;
      eth_ready  <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == RST_LAST) begin
            state      <= ST_RELEASE;
            cnt        <= '0;
            phy_resetn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == WAIT_LAST) begin
            state     <= ST_RUN;
            cnt       <= '0;
            eth_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= '0;
        end
        default: begin
          state      <= ST_ASSERT;
          cnt        <= '0;
          phy_resetn <= 1'b0;
          eth_ready  <= 1'b0;
        end
      endcase
    end
  end

  // set_10 must equal ~speed100; equality with speed100 is the mismatch being debounced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_set_10 <= 1'b0;
      stable_cnt <= '0;
    end else if (state != ST_RUN) begin
      stable_cnt <= '0;
    end else if (phy_speed100_s == mac_set_10) begin
      if (stable_cnt == STABLE_LAST) begin
        mac_set_10 <= ~phy_speed100_s;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_eth_phy_reset_seq.sv
// tb/tb_eth_phy_reset_seq.sv - directed self-checking bench for eth_phy_reset_seq
module tb_eth_phy_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       nenet_reg_reset;
  logic       pll_locked;
  logic       phy_speed100;
  logic       emif_init_done;
  logic       emif_cal_success;
  logic       emif_cal_fail;
  logic       phy_resetn;
  logic       mac_set_10;
  logic       mac_set_1000;
  logic       eth_ready;
  logic [2:0] ddr3_status;
  logic [7:0] reset_count;

  int checks = 0;
  int errors = 0;

  eth_phy_reset_seq #(
    .RST_CYCLES   (8),
    .WAIT_CYCLES  (4),
    .STABLE_CYCLES(3),
    .CNT_W        (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .nenet_reg_reset (nenet_reg_reset),
    .pll_locked      (pll_locked),
    .phy_speed100    (phy_speed100),
    .emif_init_done  (emif_init_done),
    .emif_cal_success(emif_cal_success),
    .emif_cal_fail   (emif_cal_fail),
    .phy_resetn      (phy_resetn),
    .mac_set_10      (mac_set_10),
    .mac_set_1000    (mac_set_1000),
    .eth_ready       (eth_ready),
    .ddr3_status     (ddr3_status),
    .reset_count     (reset_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset            = 1'b1;
    nenet_reg_reset  = 1'b0;
    pll_locked       = 1'b1;
    phy_speed100     = 1'b1;
    emif_init_done   = 1'b0;
    emif_cal_success = 1'b0;
    emif_cal_fail    = 1'b0;
    tick(3);
    check("rst_phy_resetn", phy_resetn, 0);
    check("rst_eth_ready", eth_ready, 0);
    check("rst_set_10", mac_set_10, 0);
    check("rst_ddr3", ddr3_status, 0);
    check("rst_count", reset_count, 0);

    // Power-up: phy_resetn at edge 10, eth_ready at edge 14
    reset = 1'b0;
    tick(9);
    check("pu_resetn_e9", phy_resetn, 0);
    tick(1);
    check("pu_resetn_e10", phy_resetn, 1);
    check("pu_ready_e10", eth_ready, 0);
    tick(3);
    check("pu_ready_e13", eth_ready, 0);
    tick(1);
    check("pu_ready_e14", eth_ready, 1);
    check("pu_count", reset_count, 0);

    // One-cycle software reset in RUN
    nenet_reg_reset = 1'b1;
    tick(1);
    nenet_reg_reset = 1'b0;
    check("sw_resetn_low", phy_resetn, 0);
    check("sw_ready_low", eth_ready, 0);
    check("sw_count", reset_count, 1);
    tick(7);
    check("sw_resetn_e8", phy_resetn, 0);
    tick(1);
    check("sw_resetn_e9", phy_resetn, 1);
    tick(4);
    check("sw_ready", eth_ready, 1);

    // 20-cycle software reset: low for 28 edges from the request
    nenet_reg_reset = 1'b1;
    tick(20);
    nenet_reg_reset = 1'b0;
    tick(7);
    check("hold20_low_27", phy_resetn, 0);
    tick(1);
    check("hold20_high_28", phy_resetn, 1);
    check("hold20_count", reset_count, 2);

    // PLL loss for one cycle while in RELEASE
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("pll_resetn_e2", phy_resetn, 1);
    tick(1);
    check("pll_resetn_e3", phy_resetn, 0);
    check("pll_count", reset_count, 3);
    tick(7);
    check("pll_resetn_e10", phy_resetn, 0);
    tick(1);
    check("pll_resetn_e11", phy_resetn, 1);
    tick(4);
    check("pll_ready", eth_ready, 1);

    // Speed glitch shorter than the debounce window, then a real change
    phy_speed100 = 1'b0;
    tick(2);
    phy_speed100 = 1'b1;
    tick(6);
    check("glitch_set_10", mac_set_10, 0);
    phy_speed100 = 1'b0;
    tick(4);
    check("speed_e4", mac_set_10, 0);
    tick(1);
    check("speed_e5", mac_set_10, 1);
    check("set_1000", mac_set_1000, 0);

    // DDR3 status synchronizer latency
    emif_init_done   = 1'b1;
    emif_cal_success = 1'b1;
    tick(1);
    check("ddr3_e1", ddr3_status, 3'b000);
    tick(1);
    check("ddr3_e2", ddr3_status, 3'b011);

    // Restart counter saturation
    for (int i = 0; i < 300; i++) begin
      int waited;
      nenet_reg_reset = 1'b1;
      tick(1);
      nenet_reg_reset = 1'b0;
      waited = 0;
      while (!eth_ready && waited < 100) begin
        tick(1);
        waited++;
      end
      if (!eth_ready) begin
        check("sat_ready_timeout", eth_ready, 1);
        break;
      end
    end
    check("sat_count", reset_count, 255);
    check("sat_set_1000", mac_set_1000, 0);
    check("sat_set_10", mac_set_10, 1);

    // Asynchronous reset mid-RUN clears outputs without a clock edge
    reset = 1'b1;
    #1;
    check("ar_phy_resetn", phy_resetn, 0);
    check("ar_eth_ready", eth_ready, 0);
    check("ar_set_10", mac_set_10, 0);
    check("ar_ddr3", ddr3_status, 0);
    check("ar_count", reset_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_phy_reset_seq.md
# eth_phy_reset_seq

Board-level sequencer between the Ethernet PHY pins and the Qsys system's TSE MAC/PIO conduits. It drives the PHY hardware reset with timed assert and settle intervals, and restarts that sequence on PLL loss of lock or a software reset request from the `nenet_reg_reset` PIO. It debounces the PHY speed indication into the MAC `set_10`/`set_1000` status inputs. It also synchronizes the DDR3 EMIF status flags into the 3-bit `ddr3_status` PIO input.

## Interface
- `RST_CYCLES`, default 500000: cycles `phy_resetn` is held low (10 ms at 50 MHz).
- `WAIT_CYCLES`, default 250000: cycles after release before `eth_ready` is asserted.
- `STABLE_CYCLES`, default 1024: cycles the speed input must hold a new value before the MAC status changes.
- `CNT_W`, default 20: counter width; must hold max(`RST_CYCLES`, `WAIT_CYCLES`, `STABLE_CYCLES`).
- `clk` input 1: single clock for all logic (the 50 MHz `clk_clk` domain).
- `reset` input 1: asynchronous, active-high reset.
- `nenet_reg_reset` input 1: software PHY reset request, synchronous to `clk`, level-sensitive.
- `pll_locked` input 1: TSE clock PLL lock, asynchronous.
- `phy_speed100` input 1: PHY speed strap/LED (1 = 100 Mb/s), asynchronous.
- `emif_init_done`, `emif_cal_success`, `emif_cal_fail` input 1 each: asynchronous EMIF status.
- `phy_resetn` output 1: PHY hardware reset, active-low.
- `mac_set_10` output 1: to the MAC `set_10` input.
- `mac_set_1000` output 1: to the MAC `set_1000` input; always 0 (MII board).
- `eth_ready` output 1: PHY out of reset and settled.
- `ddr3_status` output 3: {cal_fail, cal_success, init_done}, synchronized.
- `reset_count` output 8: number of sequence restarts; saturates at 255.

## Operation
- **Synchronizers.** `pll_locked`, `phy_speed100` and the three EMIF flags each pass through a 2-flop synchronizer, reset to 0. `ddr3_status` is the synchronizer output, so it lags the inputs by 2 cycles.
- **FSM states.** ASSERT, RELEASE, RUN. Async reset enters ASSERT with the counter at 0.
- **Hold condition.** The hold is `nenet_reg_reset == 1` OR `pll_locked_s == 0`.
  - In any state, hold forces the next state to ASSERT with the counter at 0.
  - While hold persists, the block stays in ASSERT and the counter stays at 0.
- **ASSERT.**
  - `phy_resetn` = 0 and `eth_ready` = 0.
  - The counter increments each non-hold cycle.
  - When the counter reaches `RST_CYCLES`-1 on a non-hold cycle, go to RELEASE and clear the counter.
- **RELEASE.**
  - `phy_resetn` = 1 and `eth_ready` = 0.
  - When the counter reaches `WAIT_CYCLES`-1, go to RUN.
- **RUN.** `phy_resetn` = 1 and `eth_ready` = 1.
- **Restart counting.** `reset_count` increments by 1 on each transition from RELEASE or RUN into ASSERT, saturating at 255. The initial async-reset entry does not count.
- **Speed debounce.**
  - Active only in RUN; outside RUN, `mac_set_10` holds its value and the stable counter is 0.
  - If `phy_speed100_s` == `mac_set_10` (a mismatch: set_10 should equal NOT speed100), the stable counter increments. Any cycle without the mismatch clears it.
  - When the stable counter reaches `STABLE_CYCLES`-1 while still mismatched, the block sets `mac_set_10` = ~`phy_speed100_s` and clears the counter.
- **Reset values.** All outputs are 0 (`phy_resetn` = 0, i.e. PHY in reset).

## Timing
- All outputs are registered and change with the state, so each output responds one `clk` edge after its cause is present at the register input.
- A hold input on `nenet_reg_reset` takes effect on the next edge: `phy_resetn`/`eth_ready` go low 1 cycle after `nenet_reg_reset` rises. For `pll_locked` falling, add the 2-cycle synchronizer (3 cycles total).
- `phy_resetn` low time is exactly `RST_CYCLES` cycles after the last hold cycle. `eth_ready` rises exactly `WAIT_CYCLES` cycles after `phy_resetn` rises.
- From async reset release with `pll_locked` already high and `nenet_reg_reset` low, `phy_resetn` rises at edge 2+`RST_CYCLES`.
- Hold asserted during RELEASE or RUN for a single cycle still restarts the full sequence.
- Speed change latency: 2 (synchronizer) + `STABLE_CYCLES` edges to a change on `mac_set_10`. A glitch shorter than `STABLE_CYCLES` produces no change.

## Test plan
- **Power-up** (`RST_CYCLES`=8, `WAIT_CYCLES`=4, `pll_locked`=1, release reset) -> `phy_resetn` rises at edge 10, `eth_ready` rises at edge 14, `reset_count`=0.
- **Software reset in RUN** (pulse `nenet_reg_reset` 1 cycle) -> `eth_ready` and `phy_resetn` low 1 cycle later, `phy_resetn` low for 8 cycles, `reset_count`=1. Holding `nenet_reg_reset` high for 20 cycles keeps `phy_resetn` low for 28 cycles.
- **PLL loss in RELEASE** (drop `pll_locked` for 1 cycle) -> `phy_resetn` low 3 cycles later, full sequence replays, `reset_count` increments.
- **Speed debounce** (`STABLE_CYCLES`=3, in RUN, `phy_speed100` 1 -> 0) -> `mac_set_10` = 1 five edges after the change. A 2-cycle 0 glitch on `phy_speed100` leaves `mac_set_10` = 0. `mac_set_1000` stays 0 throughout.
- **Saturation** (300 `nenet_reg_reset` pulses, each after RUN) -> `reset_count` = 255.
- **DDR3 status** (set init_done and cal_success) -> `ddr3_status` = 3'b011 two edges later. Async `reset` mid-RUN -> all outputs 0 immediately.
